// File: rtl/ram_dp_fill_if.sv
// Port bundle for ram_dp_fill: CPU read/write port, video read port, fill control/status.
// master drives addresses, data and fill requests; slave is the RAM.
interface ram_dp_fill_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic          ce;
    logic          we;
    logic [AW-1:0] a1;
    logic [DW-1:0] din;
    logic [DW-1:0] dout1;
    logic [AW-1:0] a2;
    logic [DW-1:0] dout2;
    logic          fill_start;
    logic [DW-1:0] fill_value;
    logic          busy;
    logic          done;

    modport master (
        output ce, we, a1, din, a2, fill_start, fill_value,
        input  dout1, dout2, busy, done
    );

    modport slave (
        input  ce, we, a1, din, a2, fill_start, fill_value,
        output dout1, dout2, busy, done
    );
endinterface

// File: rtl/ram_dp_fill.sv
// Dual-port RAM (port 1 R/W, port 2 read-only) with a fill engine writing one word per cycle.
// Reads 1 cycle, read-first; a fill takes 2**AW cycles and blocks port-1 writes and dout1 updates.
module ram_dp_fill #(
    parameter int            AW            = 10,
    parameter int            DW            = 8,
    parameter logic [DW-1:0] FILL_DEFAULT  = 8'h41,
    parameter bit            INIT_ON_RESET = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    ram_dp_fill_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] fill_word;
    logic          busy_r;
    logic          done_r;
    logic [DW-1:0] dout1_r;
    logic [DW-1:0] dout2_r;
    logic          cpu_wr;

    logic [DW-1:0] mem [DEPTH];

    // busy_r is high exactly while in ST_FILL, so it doubles as the fill-owns-port-1 flag
    assign cpu_wr = bus.ce & bus.we & ~busy_r;

    always_ff @(posedge clk) begin : fsm
        if (rst) begin
            state     <= INIT_ON_RESET ? ST_FILL : ST_IDLE;
            busy_r    <= INIT_ON_RESET;
            done_r    <= 1'b0;
            cnt       <= '0;
            fill_word <= FILL_DEFAULT;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.fill_start) begin
                        fill_word <= bus.fill_value;
                        cnt       <= '0;
                        busy_r    <= 1'b1;
                        state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Contents survive rst; writes are only suppressed while it is asserted
    always_ff @(posedge clk) begin : ram_wr
        if (!rst) begin
            if (busy_r) begin
                mem[cnt] <= fill_word;
            end else if (cpu_wr) begin
                mem[bus.a1] <= bus.din;
            end
        end
    end

    always_ff @(posedge clk) begin : ram_rd
        if (rst) begin
            dout1_r <= '0;
            dout2_r <= '0;
        end else begin
            if (!busy_r) begin
                dout1_r <= mem[bus.a1];
            end
            dout2_r <= mem[bus.a2];
        end
    end

    assign bus.dout1 = dout1_r;
    assign bus.dout2 = dout2_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
endmodule

// File: tb/tb_ram_dp_fill.sv
// Bench for ram_dp_fill: one instance filling on reset, one idle after reset.
// Read expectations are queued when an address is driven and checked when the data appears.
module tb_ram_dp_fill;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    ram_dp_fill_if #(.AW(10), .DW(8)) ba ();
    ram_dp_fill_if #(.AW(10), .DW(8)) bb ();

    ram_dp_fill #(.AW(10), .DW(8), .FILL_DEFAULT(8'h41), .INIT_ON_RESET(1'b1)) u_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ba)
    );

    ram_dp_fill #(.AW(10), .DW(8), .FILL_DEFAULT(8'h41), .INIT_ON_RESET(1'b0)) u_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bb)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] model_a [1024];
    logic [7:0] model_b [1024];

    typedef struct {
        int         dut;
        int         port;
        logic [7:0] exp;
        int         cyc;
        string      tag;
    } sb_t;

    sb_t sbq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare queued reads one edge after their address was driven
    always @(negedge clk) begin : monitor
        sb_t        e;
        logic [7:0] got;
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            if (e.dut == 0) got = (e.port == 1) ? ba.dout1 : ba.dout2;
            else            got = (e.port == 1) ? bb.dout1 : bb.dout2;
            chk(e.tag, {24'h0, got}, {24'h0, e.exp});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input int dut, input int port, input logic [7:0] exp, input string tag);
        sb_t e;
        e.dut  = dut;
        e.port = port;
        e.exp  = exp;
        e.cyc  = cyc;
        e.tag  = tag;
        sbq.push_back(e);
    endtask

    function automatic logic get_busy(input int d);
        return (d == 0) ? ba.busy : bb.busy;
    endfunction

    function automatic logic get_done(input int d);
        return (d == 0) ? ba.done : bb.done;
    endfunction

    task automatic wait_fill(input int d, input string tag);
        int n = 0;
        while (get_busy(d) && n < 2000) begin
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, n, 1024);
        chk({tag, "_done"}, get_done(d), 1);
    endtask

    task automatic sweep(input int d, input string tag);
        logic [7:0] e1;
        logic [7:0] e2;
        for (int a = 0; a < 1024; a++) begin
            int pa = 1023 - a;
            e2 = (d == 0) ? model_a[a]  : model_b[a];
            e1 = (d == 0) ? model_a[pa] : model_b[pa];
            if (d == 0) begin
                ba.ce = 1'b0; ba.we = 1'b0; ba.a2 = a[9:0]; ba.a1 = pa[9:0];
            end else begin
                bb.ce = 1'b0; bb.we = 1'b0; bb.a2 = a[9:0]; bb.a1 = pa[9:0];
            end
            expect_rd(d, 2, e2, {tag, "_p2"});
            expect_rd(d, 1, e1, {tag, "_p1"});
            tick();
        end
        tick();
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k;
        logic [7:0] e;

        rst_a = 1'b1;
        rst_b = 1'b1;
        ba.ce = 1'b0; ba.we = 1'b0; ba.a1 = '0; ba.din = '0; ba.a2 = '0;
        ba.fill_start = 1'b0; ba.fill_value = '0;
        bb.ce = 1'b0; bb.we = 1'b0; bb.a1 = '0; bb.din = '0; bb.a2 = '0;
        bb.fill_start = 1'b0; bb.fill_value = '0;
        tick();

        chk("a_rst_busy", ba.busy, 1);
        chk("a_rst_done", ba.done, 0);
        chk("a_rst_dout1", ba.dout1, 0);
        chk("a_rst_dout2", ba.dout2, 0);
        chk("b_rst_busy", bb.busy, 0);
        chk("b_rst_done", bb.done, 0);
        chk("b_rst_dout1", bb.dout1, 0);
        chk("b_rst_dout2", bb.dout2, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset-triggered fill
        wait_fill(0, "a_rstfill");
        tick();
        chk("a_done_pulse", ba.done, 0);
        chk("a_idle_busy", ba.busy, 0);
        for (int i = 0; i < 1024; i++) model_a[i] = 8'h41;
        sweep(0, "a_sweep_init");

        // Read-first write, then read-back on both ports
        ba.a1 = 10'h155; ba.din = 8'hA5; ba.ce = 1'b1; ba.we = 1'b1; ba.a2 = 10'h155;
        expect_rd(0, 1, model_a[10'h155], "rdfirst_p1");
        expect_rd(0, 2, model_a[10'h155], "rdfirst_p2");
        tick();
        model_a[10'h155] = 8'hA5;
        ba.ce = 1'b0; ba.we = 1'b0;
        expect_rd(0, 1, model_a[10'h155], "wr_p1");
        expect_rd(0, 2, model_a[10'h155], "wr_p2");
        tick();

        // ce low blocks the write
        ba.ce = 1'b0; ba.we = 1'b1; ba.a1 = 10'd5; ba.din = 8'h00;
        tick();
        ba.we = 1'b0;
        expect_rd(0, 1, model_a[5], "ce_gate");
        tick();
        tick();

        // Runtime fill started together with a CPU write to 0x003
        ba.fill_start = 1'b1; ba.fill_value = 8'h20;
        ba.ce = 1'b1; ba.we = 1'b1; ba.a1 = 10'h003; ba.din = 8'h77;
        expect_rd(0, 1, model_a[3], "p1_at_start");
        tick();
        chk("fill_busy_rise", ba.busy, 1);
        chk("fill_done_low", ba.done, 0);
        model_a[3] = 8'h77;
        ba.fill_start = 1'b0; ba.fill_value = 8'h99;
        ba.din = 8'hEE;
        ba.a2 = 10'h003;
        expect_rd(0, 2, 8'h77, "start_wr_kept");
        expect_rd(0, 1, 8'h41, "p1_hold");
        tick();
        k = 1;
        while (ba.busy && k < 2000) begin
            ba.fill_start = (k == 600);
            ba.fill_value = 8'h99;
            if (k >= 300 && k < 310) begin
                int adr = (k % 2 == 0) ? k : k - 1;
                e = (adr < k) ? 8'h20 : model_a[adr];
                ba.a2 = adr[9:0];
                expect_rd(0, 2, e, "sweep_during_fill");
            end
            tick();
            k++;
        end
        chk("fill_len", k, 1024);
        chk("fill_done", ba.done, 1);
        chk("fill_done_busy", ba.busy, 0);
        // DONE cycle: port 1 writes go through, fill_start is ignored
        ba.fill_start = 1'b1; ba.fill_value = 8'h99;
        ba.ce = 1'b1; ba.we = 1'b1; ba.a1 = 10'h3FF; ba.din = 8'h5A;
        tick();
        ba.fill_start = 1'b0; ba.ce = 1'b0; ba.we = 1'b0;
        chk("start_in_done_ignored", ba.busy, 0);
        chk("done_single", ba.done, 0);
        tick();
        chk("no_restart", ba.busy, 0);
        for (int i = 0; i < 1024; i++) model_a[i] = 8'h20;
        model_a[10'h3FF] = 8'h5A;
        sweep(0, "a_sweep_fill");

        // Reset in the middle of a runtime fill restarts with the default word
        ba.fill_start = 1'b1; ba.fill_value = 8'h20;
        tick();
        ba.fill_start = 1'b0;
        for (int i = 0; i < 500; i++) tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("a_abort_busy", ba.busy, 1);
        chk("a_abort_done", ba.done, 0);
        chk("a_abort_dout1", ba.dout1, 0);
        wait_fill(0, "a_refill");
        tick();
        for (int i = 0; i < 1024; i++) model_a[i] = 8'h41;
        sweep(0, "a_sweep_abort");

        // Instance without reset fill: full 0x55 fill, then aborted 0x20 fill
        chk("b_idle", bb.busy, 0);
        bb.fill_start = 1'b1; bb.fill_value = 8'h55;
        tick();
        bb.fill_start = 1'b0;
        chk("b_busy_rise", bb.busy, 1);
        wait_fill(1, "b_fill55");
        tick();
        for (int i = 0; i < 1024; i++) model_b[i] = 8'h55;
        bb.fill_start = 1'b1; bb.fill_value = 8'h20;
        tick();
        bb.fill_start = 1'b0;
        for (int i = 0; i < 500; i++) tick();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("b_abort_idle", bb.busy, 0);
        chk("b_abort_dout2", bb.dout2, 0);
        tick();
        tick();
        chk("b_stays_idle", bb.busy, 0);
        for (int i = 0; i < 500; i++) model_b[i] = 8'h20;
        sweep(1, "b_sweep_abort");

        tick();
        chk("sb_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
